replay_rx: RTL and testbench

REPLAY_RX -- requirements
Module: replay_rx

---
 rtl/replay_rx_if.sv | 29 ++
 rtl/replay_rx.sv | 118 +++++++++++
 tb/tb_replay_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/replay_rx_if.sv
// Packet receive / delivery / ack-nak bundle of the replay receiver.
// slave = the receiver itself, master = link + consumer side.
interface replay_rx_if #(
  parameter int DATA_W = 1024,
  parameter int SEQ_W  = 3
);
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic [SEQ_W-1:0]  rx_seq;
  logic              rx_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              ack;
  logic              nak;
  logic [SEQ_W-1:0]  ack_seq;
  logic [7:0]        nak_cnt;

  modport slave (
    input  rx_valid, rx_data, rx_seq, rx_err, dout_ready,
    output rx_ready, dout, dout_valid, ack, nak, ack_seq, nak_cnt
  );

  modport master (
    output rx_valid, rx_data, rx_seq, rx_err, dout_ready,
    input  rx_ready, dout, dout_valid, ack, nak, ack_seq, nak_cnt
  );
endinterface

// File: rtl/replay_rx.sv
// Go-back-N style link receiver: in-order delivery, ack/dup-ack, NAK on
// error or gap, then wait for the replay with a periodic NAK re-issue.
module replay_rx #(
  parameter int DATA_W  = 1024,
  parameter int SEQ_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      reset,
  replay_rx_if.slave bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, REPLAY_WAIT} state_t;

  state_t            state_q, state_d;
  logic [SEQ_W-1:0]  exp_seq_q, exp_seq_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              ack_q, ack_d;
  logic              nak_q, nak_d;
  logic [SEQ_W-1:0]  ack_seq_q, ack_seq_d;
  logic [7:0]        nak_cnt_q, nak_cnt_d;

  logic             rx_ready, accept, good, dup, bad, tmo_hit;
  logic [SEQ_W-1:0] seq_prev;

  assign rx_ready = !dout_valid_q || bus.dout_ready;
  assign accept   = bus.rx_valid && rx_ready;
  assign seq_prev = exp_seq_q - SEQ_W'(1);
  assign good     = accept && !bus.rx_err && (bus.rx_seq == exp_seq_q);
  assign dup      = accept && !bus.rx_err && (bus.rx_seq == seq_prev);
  assign bad      = accept && !good && !dup;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (bad)  state_d = REPLAY_WAIT;
      REPLAY_WAIT: if (good) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // A good packet takes priority over timeout expiry in REPLAY_WAIT.
  always_comb begin
    ack_d     = 1'b0;
    nak_d     = 1'b0;
    ack_seq_d = ack_seq_q;
    tmo_d     = '0;
    case (state_q)
      IDLE: begin
        if (good || dup) begin
          ack_d     = 1'b1;
          ack_seq_d = bus.rx_seq;
        end else if (bad) begin
          nak_d     = 1'b1;
          ack_seq_d = exp_seq_q;
        end
      end
      REPLAY_WAIT: begin
        if (good) begin
          ack_d     = 1'b1;
          ack_seq_d = bus.rx_seq;
        end else if (tmo_hit) begin
          nak_d     = 1'b1;
          ack_seq_d = exp_seq_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    exp_seq_d    = good ? exp_seq_q + SEQ_W'(1) : exp_seq_q;
    dout_d       = good ? bus.rx_data : dout_q;
    dout_valid_d = good ? 1'b1 : (bus.dout_ready ? 1'b0 : dout_valid_q);
    nak_cnt_d    = (nak_d && nak_cnt_q != 8'hFF) ? nak_cnt_q + 8'd1 : nak_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_seq_q    <= '0;
      tmo_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      nak_q        <= 1'b0;
      ack_seq_q    <= '0;
      nak_cnt_q    <= '0;
    end else begin
      exp_seq_q    <= exp_seq_d;
      tmo_q        <= tmo_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ack_q        <= ack_d;
      nak_q        <= nak_d;
      ack_seq_q    <= ack_seq_d;
      nak_cnt_q    <= nak_cnt_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ack        = ack_q;
  assign bus.nak        = nak_q;
  assign bus.ack_seq    = ack_seq_q;
  assign bus.nak_cnt    = nak_cnt_q;
endmodule

// File: tb/tb_replay_rx.sv
// Directed bench for replay_rx: delivery, NAK/replay, timeout, wrap,
// backpressure and asynchronous reset.
module tb_replay_rx;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  replay_rx_if #(.DATA_W(DW), .SEQ_W(SW)) bus ();
  replay_rx #(.DATA_W(DW), .SEQ_W(SW), .TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic e);
    bus.rx_valid = 1'b1;
    bus.rx_seq   = s;
    bus.rx_data  = d;
    bus.rx_err   = e;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int nk, first_nk, last_nk, acks;

  initial begin
    reset          = 1'b1;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.rx_seq     = '0;
    bus.rx_err     = 1'b0;
    bus.dout_ready = 1'b1;
    tick();
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_ack_nak", {bus.ack, bus.nak}, 0);
    chk("rst_ack_seq", bus.ack_seq, 0);
    chk("rst_nak_cnt", bus.nak_cnt, 0);
    chk("rst_rx_ready", bus.rx_ready, 1);
    #1 reset = 1'b0;

    // back-to-back in-order delivery
    send(3'd0, 32'h0001, 1'b0);
    chk("b2b_ack0", {bus.ack, bus.nak, bus.ack_seq}, {2'b10, 3'd0});
    chk("b2b_dout0", bus.dout, 32'h0001);
    send(3'd1, 32'h1111, 1'b0);
    chk("b2b_ack1", {bus.ack, bus.nak, bus.ack_seq}, {2'b10, 3'd1});
    chk("b2b_dout1", bus.dout, 32'h1111);
    chk("b2b_dv", bus.dout_valid, 1);
    tick();
    chk("b2b_idle", {bus.ack, bus.nak, bus.dout_valid}, 3'b000);
    chk("b2b_nak_cnt", bus.nak_cnt, 0);

    // error -> NAK, gap packet dropped silently, replay accepted
    apply_reset();
    send(3'd0, 32'hA0, 1'b0);
    send(3'd1, 32'hA1, 1'b1);
    chk("err_nak", {bus.ack, bus.nak, bus.ack_seq}, {2'b01, 3'd1});
    chk("err_nak_cnt", bus.nak_cnt, 1);
    send(3'd2, 32'hA2, 1'b0);
    chk("rw_silent", {bus.ack, bus.nak}, 0);
    chk("rw_no_deliver", bus.dout_valid, 0);
    send(3'd1, 32'hB1, 1'b0);
    chk("replay_ack", {bus.ack, bus.nak, bus.ack_seq}, {2'b10, 3'd1});
    chk("replay_dout", bus.dout, 32'hB1);
    send(3'd0, 32'hC0, 1'b0);  // out of order again: NAKs only if back in IDLE
    chk("back_idle_nak", {bus.ack, bus.nak, bus.ack_seq}, {2'b01, 3'd2});
    chk("back_idle_cnt", bus.nak_cnt, 2);

    // timeout re-NAKs, then good packet exactly at expiry
    apply_reset();
    send(3'd1, 32'hD1, 1'b0);
    chk("to_first_nak", {bus.nak, bus.ack_seq, bus.nak_cnt}, {1'b1, 3'd0, 8'd1});
    nk = 0; first_nk = 0; last_nk = 0;
    for (int i = 1; i <= 2 * T; i++) begin
      tick();
      if (bus.nak) begin
        nk++;
        if (first_nk == 0) first_nk = i;
        last_nk = i;
      end
    end
    chk("to_nak_count", nk, 2);
    chk("to_first_pos", first_nk, T);
    chk("to_last_pos", last_nk, 2 * T);
    chk("to_nak_cnt", bus.nak_cnt, 3);
    repeat (T - 1) tick();
    send(3'd0, 32'hE0, 1'b0);
    chk("to_race_ack", {bus.ack, bus.nak, bus.ack_seq}, {2'b10, 3'd0});
    chk("to_race_cnt", bus.nak_cnt, 3);
    nk = 0;
    for (int i = 0; i <= T; i++) begin
      tick();
      if (bus.nak) nk++;
    end
    chk("idle_no_nak", nk, 0);

    // sequence wrap and duplicate re-ack
    apply_reset();
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      send(3'(i), 32'h100 + i, 1'b0);
      if (bus.ack && bus.ack_seq == 3'(i)) acks++;
      chk("wrap_dout", bus.dout, 32'h100 + i);
    end
    chk("wrap_acks", acks, 9);
    send(3'd0, 32'hDEAD, 1'b0);
    chk("dup_ack", {bus.ack, bus.nak, bus.ack_seq}, {2'b10, 3'd0});
    chk("dup_no_deliver", {bus.dout_valid, bus.dout}, {1'b0, 32'h108});
    send(3'd1, 32'h201, 1'b0);
    chk("wrap_next", {bus.ack, bus.ack_seq, bus.dout}, {1'b1, 3'd1, 32'h201});

    // consumer backpressure
    apply_reset();
    bus.dout_ready = 1'b0;
    send(3'd0, 32'hAAAA, 1'b0);
    chk("bp_dv", bus.dout_valid, 1);
    chk("bp_ready", bus.rx_ready, 0);
    bus.rx_valid = 1'b1;
    bus.rx_seq   = 3'd1;
    bus.rx_data  = 32'hBBBB;
    repeat (3) begin
      tick();
      chk("bp_hold", {bus.ack, bus.dout}, {1'b0, 32'hAAAA});
    end
    bus.dout_ready = 1'b1;
    #1 chk("bp_ready_comb", bus.rx_ready, 1);
    tick();
    bus.rx_valid = 1'b0;
    chk("bp_accept", {bus.ack, bus.ack_seq, bus.dout_valid, bus.dout}, {1'b1, 3'd1, 1'b1, 32'hBBBB});

    // asynchronous reset: held packet, then REPLAY_WAIT with pulse pending
    apply_reset();
    bus.dout_ready = 1'b0;
    send(3'd0, 32'h77, 1'b0);
    #2 reset = 1'b1;
    #1 chk("arst_held", {bus.dout_valid, bus.ack, bus.dout}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.dout_ready = 1'b1;
    send(3'd0, 32'h70, 1'b0);
    send(3'd3, 32'h73, 1'b0);
    chk("arst_pre", {bus.nak, bus.ack_seq, bus.nak_cnt}, {1'b1, 3'd1, 8'd1});
    #2 reset = 1'b1;
    #1 chk("arst_rw", {bus.nak, bus.ack, bus.ack_seq, bus.nak_cnt, bus.dout}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    send(3'd0, 32'h90, 1'b0);
    chk("arst_seq0", {bus.ack, bus.nak, bus.ack_seq, bus.dout}, {2'b10, 3'd0, 32'h90});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
